sym_delay_align_ctrl: RTL and testbench

Sweep controller for the configurable symbol delay line. On `start` it steps the line's 8-bit `delay` select across a programmed range. At each setting it correlates the delayed stream against a reference symbol stream over 2^LOG_N symbols, then locks `delay` to the setting with the largest correlation. It sits beside the symbol delay line in the receiver's timing/alignment path, driving its `delay` input and observing its `out`.

---
 rtl/sym_delay_align_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sym_delay_align_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sym_delay_align_ctrl.sv
// Symbol delay sweep controller: steps the delay line select over a range,
// correlates delayed symbols against the reference and locks to the best.
module sym_delay_align_ctrl #(
   parameter int DELAY_MIN = 0,
   parameter int DELAY_MAX = 255,
   parameter int LOG_N     = 8,
   parameter int SETTLE    = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      sam_clk_en,
   input  logic                      sym_clk_en,
   input  logic                      start,
   input  logic                      manual_en,
   input  logic [7:0]                manual_delay,
   input  logic signed [17:0]        ref_sym,
   input  logic signed [17:0]        dly_sym,
   output logic [7:0]                delay,
   output logic                      busy,
   output logic                      done,
   output logic                      locked,
   output logic [7:0]                best_delay,
   output logic signed [36+LOG_N-1:0] best_metric
);

   localparam int AW = 36 + LOG_N;
   localparam logic [7:0] DMIN = 8'(DELAY_MIN);
   localparam logic [7:0] DMAX = 8'(DELAY_MAX);
   localparam logic [3:0] SET_LAST = 4'(SETTLE - 1);
   localparam logic [3:0] SET_ONE = 4'd1;
   localparam logic [LOG_N-1:0] SYM_LAST = '1;
   localparam logic [LOG_N-1:0] SYM_ONE = LOG_N'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_ACCUM,
      ST_COMPARE
   } state_t;

   state_t state, state_nxt;

   logic [7:0]           delay_nxt;
   logic [3:0]           settle_cnt, settle_nxt;
   logic [LOG_N-1:0]     sym_cnt, sym_nxt;
   logic signed [AW-1:0] acc, acc_nxt;
   logic                 best_valid, bv_nxt;
   logic [7:0]           bd_nxt;
   logic signed [AW-1:0] bm_nxt;
   logic                 done_nxt;
   logic                 locked_nxt;
   logic                 win;

   logic signed [35:0]   prod;
   logic signed [AW-1:0] prod_ext;
   logic                 unused_sam;

   assign unused_sam = sam_clk_en;

   // Full-precision product, widened so 2^LOG_N terms cannot overflow
   assign prod     = ref_sym * dly_sym;
   assign prod_ext = {{LOG_N{prod[35]}}, prod};

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         delay       <= '0;
         settle_cnt  <= '0;
         sym_cnt     <= '0;
         acc         <= '0;
         best_valid  <= 1'b0;
         best_delay  <= '0;
         best_metric <= '0;
         done        <= 1'b0;
         locked      <= 1'b0;
      end else begin
         state       <= state_nxt;
         delay       <= delay_nxt;
         settle_cnt  <= settle_nxt;
         sym_cnt     <= sym_nxt;
         acc         <= acc_nxt;
         best_valid  <= bv_nxt;
         best_delay  <= bd_nxt;
         best_metric <= bm_nxt;
         done        <= done_nxt;
         locked      <= locked_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      delay_nxt  = delay;
      settle_nxt = settle_cnt;
      sym_nxt    = sym_cnt;
      acc_nxt    = acc;
      bv_nxt     = best_valid;
      bd_nxt     = best_delay;
      bm_nxt     = best_metric;
      done_nxt   = 1'b0;
      locked_nxt = locked;
      win        = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (start) begin
               delay_nxt  = DMIN;
               settle_nxt = '0;
               sym_nxt    = '0;
               acc_nxt    = '0;
               bv_nxt     = 1'b0;
               locked_nxt = 1'b0;
               state_nxt  = ST_SETTLE;
            end else if (manual_en) begin
               delay_nxt  = manual_delay;
               locked_nxt = 1'b0;
            end
         end

         ST_SETTLE: begin
            if (SETTLE == 0) begin
               state_nxt = ST_ACCUM;
            end else if (sym_clk_en) begin
               if (settle_cnt == SET_LAST) begin
                  settle_nxt = '0;
                  state_nxt  = ST_ACCUM;
               end else begin
                  settle_nxt = settle_cnt + SET_ONE;
               end
            end
         end

         ST_ACCUM: begin
            if (sym_clk_en) begin
               acc_nxt = acc + prod_ext;
               sym_nxt = sym_cnt + SYM_ONE;
               if (sym_cnt == SYM_LAST) begin
                  state_nxt = ST_COMPARE;
               end
            end
         end

         ST_COMPARE: begin
            // Strict compare: on a tie the earlier setting is kept
            win = !best_valid || (acc > best_metric);
            if (win) begin
               bm_nxt = acc;
               bd_nxt = delay;
               bv_nxt = 1'b1;
            end
            if (delay == DMAX) begin
               delay_nxt  = win ? delay : best_delay;
               done_nxt   = 1'b1;
               locked_nxt = 1'b1;
               state_nxt  = ST_IDLE;
            end else begin
               delay_nxt  = delay + 8'd1;
               acc_nxt    = '0;
               settle_nxt = '0;
               sym_nxt    = '0;
               state_nxt  = ST_SETTLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sym_delay_align_ctrl.sv
// Directed bench for sym_delay_align_ctrl: lock, tie, signed compare,
// extreme values, reset abort, start/manual handling and enable gaps.
module tb_sym_delay_align_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int   n_run  = 0;
   int   n_fail = 0;
   int   cyc;
   int   ndone;

   // Instance A: 0..31, LOG_N=6, SETTLE=2, PN stream lagged by 17
   logic               start_a, man_en_a, sym_en_a, neg_a;
   logic [7:0]         man_dly_a;
   logic signed [17:0] ref_a, dly_a;
   logic [7:0]         delay_a, bd_a;
   logic               busy_a, done_a, locked_a;
   logic signed [41:0] bm_a;

   logic [63:0] hist = '0;
   logic [6:0]  lfsr = 7'h01;

   always @(posedge clk) begin
      if (sym_en_a) begin
         lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
         hist <= {hist[62:0], lfsr[0]};
      end
   end

   assign ref_a = hist[17] ? -18'sd65536 : 18'sd65536;
   assign dly_a = neg_a ? ((delay_a == 8'd3) ? 18'sd0 : -ref_a)
                        : (hist[delay_a[5:0]] ? -18'sd65536 : 18'sd65536);

   sym_delay_align_ctrl #(
      .DELAY_MIN(0), .DELAY_MAX(31), .LOG_N(6), .SETTLE(2)
   ) u_a (
      .clk(clk), .reset_n(reset_n), .sam_clk_en(1'b1),
      .sym_clk_en(sym_en_a), .start(start_a),
      .manual_en(man_en_a), .manual_delay(man_dly_a),
      .ref_sym(ref_a), .dly_sym(dly_a),
      .delay(delay_a), .busy(busy_a), .done(done_a),
      .locked(locked_a), .best_delay(bd_a), .best_metric(bm_a)
   );

   // Instance B: 5..8, constant equal streams for the tie rule
   logic               start_b;
   logic signed [17:0] k_b;
   logic [7:0]         delay_b, bd_b;
   logic               busy_b, done_b, locked_b;
   logic signed [39:0] bm_b;

   sym_delay_align_ctrl #(
      .DELAY_MIN(5), .DELAY_MAX(8), .LOG_N(4), .SETTLE(1)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .sam_clk_en(1'b0),
      .sym_clk_en(1'b1), .start(start_b),
      .manual_en(1'b0), .manual_delay(8'd0),
      .ref_sym(k_b), .dly_sym(k_b),
      .delay(delay_b), .busy(busy_b), .done(done_b),
      .locked(locked_b), .best_delay(bd_b), .best_metric(bm_b)
   );

   // Instance D: single setting, most negative inputs, LOG_N=12
   logic               start_d;
   logic signed [17:0] k_d;
   logic [7:0]         delay_d, bd_d;
   logic               busy_d, done_d, locked_d;
   logic signed [47:0] bm_d;

   sym_delay_align_ctrl #(
      .DELAY_MIN(7), .DELAY_MAX(7), .LOG_N(12), .SETTLE(0)
   ) u_d (
      .clk(clk), .reset_n(reset_n), .sam_clk_en(1'b0),
      .sym_clk_en(1'b1), .start(start_d),
      .manual_en(1'b0), .manual_delay(8'd0),
      .ref_sym(k_d), .dly_sym(k_d),
      .delay(delay_d), .busy(busy_d), .done(done_d),
      .locked(locked_d), .best_delay(bd_d), .best_metric(bm_d)
   );

   task automatic check(input string tag, input longint got,
                        input longint exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic run_a(input int gap_at, input int poke_at,
                        output int n);
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("a_busy_rise", busy_a, 1);
      check("a_lock_clr", locked_a, 0);
      n = 0;
      while (!done_a && n < 6000) begin
         @(negedge clk);
         n++;
         if (n == gap_at) sym_en_a = 1'b0;
         if (n == gap_at + 100) sym_en_a = 1'b1;
         if (n == poke_at) start_a = 1'b1;
         if (n == poke_at + 1) start_a = 1'b0;
      end
      if (!done_a) check("a_timeout", 0, 1);
   endtask

   initial begin
      reset_n   = 1'b0;
      start_a   = 1'b0;
      man_en_a  = 1'b0;
      man_dly_a = 8'd0;
      sym_en_a  = 1'b1;
      neg_a     = 1'b0;
      start_b   = 1'b0;
      k_b       = 18'sd1000;
      start_d   = 1'b0;
      k_d       = 18'sh20000;

      repeat (3) @(negedge clk);
      check("rst_delay", delay_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_locked", locked_a, 0);
      check("rst_bdelay", bd_a, 0);
      check("rst_bmetric", bm_a, 0);
      reset_n = 1'b1;
      repeat (80) @(negedge clk);

      // PN alignment: peak at 17, metric 64 * 2^32
      run_a(-1, -1, cyc);
      check("lock_cycles", cyc, 2144);
      check("lock_done", done_a, 1);
      check("lock_busy", busy_a, 0);
      check("lock_bdelay", bd_a, 17);
      check("lock_delay", delay_a, 17);
      check("lock_locked", locked_a, 1);
      check("lock_metric", bm_a, 64'sd274877906944);
      @(negedge clk);
      check("done_1clk", done_a, 0);
      check("lock_hold", bd_a, 17);

      man_en_a  = 1'b1;
      man_dly_a = 8'd200;
      @(negedge clk);
      check("man_delay", delay_a, 200);
      check("man_locked", locked_a, 0);
      man_en_a = 1'b0;

      // All settings anti-correlated except 3, which is zero
      neg_a = 1'b1;
      run_a(-1, -1, cyc);
      check("neg_cycles", cyc, 2144);
      check("neg_bdelay", bd_a, 3);
      check("neg_delay", delay_a, 3);
      check("neg_metric", bm_a, 0);
      neg_a = 1'b0;

      // 100-clk enable gap in ACCUM plus a start poke while busy
      run_a(20, 60, cyc);
      check("gap_cycles", cyc, 2244);
      check("gap_bdelay", bd_a, 17);
      check("gap_metric", bm_a, 64'sd274877906944);

      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      cyc = 0;
      while (!done_b && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      check("tie_cycles", cyc, 72);
      check("tie_bdelay", bd_b, 5);
      check("tie_delay", delay_b, 5);
      check("tie_locked", locked_b, 1);
      check("tie_metric", bm_b, 16000000);

      @(negedge clk);
      start_d = 1'b1;
      @(negedge clk);
      start_d = 1'b0;
      cyc = 0;
      while (!done_d && cyc < 6000) begin
         @(negedge clk);
         cyc++;
      end
      check("ext_cycles", cyc, 4098);
      check("ext_bdelay", bd_d, 7);
      check("ext_delay", delay_d, 7);
      check("ext_metric", bm_d, 64'sd70368744177664);

      // Reset mid-ACCUM aborts with no done
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_busy", busy_a, 1);
      reset_n = 1'b0;
      #1;
      check("abort_delay", delay_a, 0);
      check("abort_busy0", busy_a, 0);
      check("abort_locked", locked_a, 0);
      check("abort_bdelay", bd_a, 0);
      check("abort_bmetric", bm_a, 0);
      @(negedge clk);
      reset_n = 1'b1;
      ndone = 0;
      repeat (300) begin
         @(negedge clk);
         if (done_a) ndone++;
      end
      check("abort_nodone", ndone, 0);
      check("abort_idle", busy_a, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
